// File: rtl/dma_master.sv
// dma_master
// Bus master that copies a block of 32-bit words from a source address range
// to a destination address range, one read/write pair per word.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     one-cycle launch pulse, honoured only when idle
//   src_addr  first source word address (sampled on accepted start)
//   dst_addr  first destination word address (sampled on accepted start)
//   length    number of words to move (sampled on accepted start)
//   busy      high from accepted start until the cycle after done
//   done      one-cycle completion pulse
//   m_req     bus request, held for the whole transfer
//   m_grant   bus grant from the arbiter
//   m_wr      1 = write cycle, 0 = read cycle
//   m_addr    bus address
//   m_dout    write data to the bus
//   m_din     read data from the bus
//
// Every output is a register; the next-state block computes the value each
// output must show during the state being entered.
module dma_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_reg,  state_next;
  logic [ADDR_W-1:0] src_reg,    src_next;
  logic [ADDR_W-1:0] dst_reg,    dst_next;
  logic [LEN_W-1:0]  count_reg,  count_next;
  logic [DATA_W-1:0] data_reg,   data_next;
  logic              busy_reg,   busy_next;
  logic              done_reg,   done_next;
  logic              req_reg,    req_next;
  logic              wr_reg,     wr_next;
  logic [ADDR_W-1:0] addr_reg,   addr_next;
  logic [DATA_W-1:0] dout_reg,   dout_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      count_reg <= '0;
      data_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      req_reg   <= 1'b0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      count_reg <= count_next;
      data_reg  <= data_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      req_reg   <= req_next;
      wr_reg    <= wr_next;
      addr_reg  <= addr_next;
      dout_reg  <= dout_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    count_next = count_reg;
    data_next  = data_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    req_next   = req_reg;
    wr_next    = wr_reg;
    addr_next  = addr_reg;
    dout_next  = dout_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          busy_next = 1'b1;
          if (length != '0) begin
            src_next   = src_addr;
            dst_next   = dst_addr;
            count_next = length;
            req_next   = 1'b1;
            state_next = S_REQ;
          end else begin
            // Empty block: report completion without touching the bus.
            done_next  = 1'b1;
            state_next = S_DONE;
          end
        end
      end

      S_REQ: begin
        wr_next = 1'b0;
        if (m_grant) begin
          // Retry (or first attempt) always restarts at the read of the
          // current word, so nothing is skipped or repeated.
          addr_next  = src_reg;
          state_next = S_RD;
        end
      end

      S_RD: begin
        if (!m_grant) begin
          state_next = S_REQ;
        end else begin
          state_next = S_CAP;
        end
      end

      S_CAP: begin
        if (!m_grant) begin
          state_next = S_REQ;
        end else begin
          // Slave read data arrives one cycle after the read address.
          data_next  = m_din;
          dout_next  = m_din;
          addr_next  = dst_reg;
          wr_next    = 1'b1;
          state_next = S_WR;
        end
      end

      S_WR: begin
        wr_next = 1'b0;
        if (!m_grant) begin
          // Write did not reach the slave; keep pointers and retry the word.
          state_next = S_REQ;
        end else begin
          src_next   = src_reg + ADDR_W'(1);
          dst_next   = dst_reg + ADDR_W'(1);
          count_next = count_reg - LEN_W'(1);
          if (count_reg == LEN_W'(1)) begin
            req_next   = 1'b0;
            done_next  = 1'b1;
            state_next = S_DONE;
          end else begin
            addr_next  = src_reg + ADDR_W'(1);
            state_next = S_RD;
          end
        end
      end

      S_DONE: begin
        req_next   = 1'b0;
        wr_next    = 1'b0;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign m_req  = req_reg;
  assign m_wr   = wr_reg;
  assign m_addr = addr_reg;
  assign m_dout = dout_reg;

endmodule

// File: tb/tb_dma_master.sv
// tb_dma_master
// Drives dma_master against a behavioural slave (registered read, responds
// only while granted) and checks the observed write stream against a model
// that derives each expected write as (dst+i, mem[src+i]) modulo 2^16.
module tb_dma_master;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic        m_req;
  logic        m_grant;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [31:0] m_dout;
  logic [31:0] m_din;

  int checks;
  int failures;

  dma_master #(
    .ADDR_W(16),
    .DATA_W(32),
    .LEN_W (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .length  (length),
    .busy    (busy),
    .done    (done),
    .m_req   (m_req),
    .m_grant (m_grant),
    .m_wr    (m_wr),
    .m_addr  (m_addr),
    .m_dout  (m_dout),
    .m_din   (m_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave memory and bus observation
  logic [31:0] mem [0:65535];
  logic        rd_pend;
  logic [15:0] rd_a;
  logic [15:0] wq_addr [$];
  logic [31:0] wq_data [$];
  int          done_count;
  logic        req_seen;

  // Per-cycle trace of the current transfer (cycle 1 = first cycle after
  // the start edge)
  logic [15:0] tr_addr [0:63];
  logic        tr_wr   [0:63];
  logic        tr_req  [0:63];
  logic [31:0] tr_dout [0:63];
  logic        busy_after;

  always @(negedge clk) begin
    rd_pend = m_req && m_grant && !m_wr;
    rd_a    = m_addr;
    if (reset_n && m_req && m_grant && m_wr) begin
      wq_addr.push_back(m_addr);
      wq_data.push_back(m_dout);
    end
    if (done) done_count++;
    if (m_req) req_seen = 1'b1;
  end

  // Registered read; garbage when the access was not granted.
  always @(posedge clk) begin
    m_din <= rd_pend ? mem[rd_a] : $urandom;
  end

  // Runs one transfer. Grant is low in cycles [lo,hi] and otherwise dropped
  // with probability pct%. A competing start pulse is issued in cycle rs_cyc.
  task automatic do_xfer(input logic [15:0] s, input logic [15:0] d,
                         input logic [7:0] n, input int lo, input int hi,
                         input int pct, input int rs_cyc,
                         output int done_cyc);
    int c;
    wq_addr.delete();
    wq_data.delete();
    done_count = 0;
    req_seen   = 1'b0;
    done_cyc   = -1;
    @(posedge clk); #1;
    m_grant  = 1'b1;
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    length   = n;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (c < 600) begin
      if (c < 64) begin
        tr_addr[c] = m_addr;
        tr_wr[c]   = m_wr;
        tr_req[c]  = m_req;
        tr_dout[c] = m_dout;
      end
      m_grant = !((c >= lo && c <= hi) || (int'($urandom_range(99)) < pct));
      if (c == rs_cyc) begin
        start    = 1'b1;
        src_addr = 16'h0600;
        dst_addr = 16'h0700;
        length   = 8'd5;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    m_grant = 1'b1;
    start   = 1'b0;
    @(posedge clk); #1;
    busy_after = busy;
    repeat (3) @(posedge clk);
    #1;
    $display("xfer src=%h dst=%h len=%0d writes=%0d done_cyc=%0d",
             s, d, n, wq_addr.size(), done_cyc);
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    start    = 1'b0;
    m_grant  = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    #12;
    checks++;
    if ({busy, done, m_req, m_wr} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0000", {busy, done, m_req, m_wr});
    end
    checks++;
    if ({m_addr, m_dout} !== 48'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h want=0", {m_addr, m_dout});
    end
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, m_req, m_wr, m_addr, m_dout} !== 52'h0) begin
      failures++;
      $display("FAIL reset_idle got=%h want=0", {busy, done, m_req, m_wr, m_addr, m_dout});
    end
  endtask

  task automatic test_single;
    int dc;
    mem[16'h0001] = 32'h0000_00AA;
    do_xfer(16'h0001, 16'h0201, 8'd1, 0, -1, 0, 0, dc);
    checks++;
    if (tr_addr[2] !== 16'h0001 || tr_wr[2] !== 1'b0) begin
      failures++;
      $display("FAIL single_rd addr=%h wr=%b want addr=0001 wr=0", tr_addr[2], tr_wr[2]);
    end
    checks++;
    if (tr_addr[4] !== 16'h0201 || tr_wr[4] !== 1'b1 || tr_dout[4] !== 32'h0000_00AA) begin
      failures++;
      $display("FAIL single_wr addr=%h wr=%b dout=%h want 0201/1/000000aa",
               tr_addr[4], tr_wr[4], tr_dout[4]);
    end
    checks++;
    if (dc !== 5 || done_count !== 1) begin
      failures++;
      $display("FAIL single_done cyc=%0d pulses=%0d want cyc=5 pulses=1", dc, done_count);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      failures++;
      $display("FAIL single_busy got=%b want=0", busy_after);
    end
  endtask

  task automatic test_block4;
    int dc;
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i) + 32'h10;
    do_xfer(16'h0100, 16'h0300, 8'd4, 0, -1, 0, 0, dc);
    checks++;
    if (wq_addr.size() !== 4) begin
      failures++;
      $display("FAIL block4_count got=%0d want=4", wq_addr.size());
    end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      checks++;
      if (wq_addr[i] !== 16'h0300 + 16'(i) || wq_data[i] !== 32'h110 + 32'(i)) begin
        failures++;
        $display("FAIL block4_wr%0d got=%h/%h want=%h/%h", i, wq_addr[i], wq_data[i],
                 16'h0300 + 16'(i), 32'h110 + 32'(i));
      end
    end
    // Grant seen in cycle 1; completion 4*3+1 cycles later.
    checks++;
    if (dc - 1 !== 13) begin
      failures++;
      $display("FAIL block4_latency got=%0d want=13", dc - 1);
    end
  endtask

  task automatic test_grant_loss;
    int dc;
    logic req_ok;
    do_xfer(16'h0100, 16'h0300, 8'd4, 6, 7, 0, 0, dc);
    checks++;
    if (tr_wr[7] !== 1'b0 || tr_wr[8] !== 1'b0) begin
      failures++;
      $display("FAIL gl_wr_low got=%b%b want=00", tr_wr[7], tr_wr[8]);
    end
    checks++;
    if (tr_addr[9] !== 16'h0101 || tr_wr[9] !== 1'b0) begin
      failures++;
      $display("FAIL gl_reread addr=%h wr=%b want=0101/0", tr_addr[9], tr_wr[9]);
    end
    req_ok = 1'b1;
    for (int c = 1; c < 18; c++) if (tr_req[c] !== 1'b1) req_ok = 1'b0;
    checks++;
    if (req_ok !== 1'b1) begin
      failures++;
      $display("FAIL gl_req_held got=%b want=1", req_ok);
    end
    checks++;
    if (wq_addr.size() !== 4) begin
      failures++;
      $display("FAIL gl_count got=%0d want=4", wq_addr.size());
    end
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      checks++;
      if (wq_addr[i] !== 16'h0300 + 16'(i) || wq_data[i] !== 32'h110 + 32'(i)) begin
        failures++;
        $display("FAIL gl_wr%0d got=%h/%h want=%h/%h", i, wq_addr[i], wq_data[i],
                 16'h0300 + 16'(i), 32'h110 + 32'(i));
      end
    end
    checks++;
    if (dc !== 18) begin
      failures++;
      $display("FAIL gl_done_cyc got=%0d want=18", dc);
    end
  endtask

  task automatic test_wrap_zero;
    int dc;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    do_xfer(16'hFFFF, 16'h00FE, 8'd2, 0, -1, 0, 0, dc);
    checks++;
    if (tr_addr[2] !== 16'hFFFF || tr_addr[5] !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_rd got=%h,%h want=ffff,0000", tr_addr[2], tr_addr[5]);
    end
    checks++;
    if (wq_addr.size() !== 2) begin
      failures++;
      $display("FAIL wrap_count got=%0d want=2", wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 16'h00FE || wq_data[0] !== mem[16'hFFFF] ||
          wq_addr[1] !== 16'h00FF || wq_data[1] !== mem[16'h0000]) begin
        failures++;
        $display("FAIL wrap_wr got=%h/%h %h/%h want=00fe/%h 00ff/%h", wq_addr[0], wq_data[0],
                 wq_addr[1], wq_data[1], mem[16'hFFFF], mem[16'h0000]);
      end
    end
    do_xfer(16'h1234, 16'h5678, 8'd0, 0, -1, 0, 0, dc);
    checks++;
    if (dc !== 1 || done_count !== 1) begin
      failures++;
      $display("FAIL zero_done cyc=%0d pulses=%0d want cyc=1 pulses=1", dc, done_count);
    end
    checks++;
    if (req_seen !== 1'b0 || wq_addr.size() !== 0) begin
      failures++;
      $display("FAIL zero_bus req=%b writes=%0d want req=0 writes=0", req_seen, wq_addr.size());
    end
  endtask

  task automatic test_start_ignored;
    int dc;
    do_xfer(16'h0400, 16'h0500, 8'd3, 0, -1, 0, 4, dc);
    checks++;
    if (wq_addr.size() !== 3 || done_count !== 1) begin
      failures++;
      $display("FAIL ign_count writes=%0d pulses=%0d want 3/1", wq_addr.size(), done_count);
    end
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      checks++;
      if (wq_addr[i] !== 16'h0500 + 16'(i) || wq_data[i] !== mem[16'h0400 + 16'(i)]) begin
        failures++;
        $display("FAIL ign_wr%0d got=%h/%h want=%h/%h", i, wq_addr[i], wq_data[i],
                 16'h0500 + 16'(i), mem[16'h0400 + 16'(i)]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ign_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_mid_reset;
    int wcount;
    wq_addr.delete();
    wq_data.delete();
    @(posedge clk); #1;
    m_grant  = 1'b1;
    start    = 1'b1;
    src_addr = 16'h0800;
    dst_addr = 16'h0900;
    length   = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({m_req, busy, m_wr} !== 3'b000) begin
      failures++;
      $display("FAIL midrst_async got=%b want=000", {m_req, busy, m_wr});
    end
    wcount = wq_addr.size();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wq_addr.size() !== wcount || m_req !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet writes=%0d req=%b want writes=%0d req=0",
               wq_addr.size(), m_req, wcount);
    end
    @(negedge clk);
    reset_n = 1'b1;
    $display("midreset writes_before=%0d", wcount);
  endtask

  task automatic test_random;
    int dc;
    logic [15:0] s, d;
    logic [7:0]  n;
    int          bad;
    for (int t = 0; t < 8; t++) begin
      s = 16'($urandom);
      d = 16'($urandom);
      n = 8'($urandom_range(12, 1));
      do_xfer(s, d, n, 0, -1, 25, 0, dc);
      checks++;
      if (wq_addr.size() !== int'(n) || done_count !== 1 || dc < 0) begin
        failures++;
        $display("FAIL rand%0d_count writes=%0d pulses=%0d done_cyc=%0d want writes=%0d pulses=1",
                 t, wq_addr.size(), done_count, dc, n);
      end
      bad = 0;
      for (int i = 0; i < int'(n) && i < wq_addr.size(); i++) begin
        if (wq_addr[i] !== 16'(d + 16'(i)) || wq_data[i] !== mem[16'(s + 16'(i))]) bad++;
      end
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL rand%0d_data bad_words=%0d want=0", t, bad);
      end
      checks++;
      if (busy_after !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_busy got=%b want=0", t, busy_after);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    done_count = 0;
    req_seen   = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i) + 32'h10;
    test_reset();
    test_single();
    test_block4();
    test_grant_loss();
    test_wrap_zero();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
